match_pu_scheduler: RTL and testbench
=====================================

Name: match_pu_scheduler

Overview:
- Shares one match_pu between SLOT_NUM requesting slots, one slot per match-engine lane.
- Each slot presents single or burst match requests. The block picks one by round-robin, registers it into the match_pu input, and tracks one outstanding request per slot.
- Responses from the match_pu are routed back to the owning slot by slot index.
- Sits between the per-slot request logic and match_pu in the match engine.

Parameters:
- SLOT_NUM, 4, number of requesting slots; equals `MATCH_PU_NUM.
- SLOT_IDX_W, 2, log2(SLOT_NUM); equals `MATCH_PU_NUM_LOG2.
- ADDR_W, `ADDR_WIDTH, address width.
- MLEN_W, `MAX_MATCH_LEN_LOG2+1, match length width.
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  SLOT_NUM  per-slot request valid
- req_is_burst  in  SLOT_NUM  per-slot burst flag
- req_head_addr  in  SLOT_NUM*ADDR_W  per-slot head address; slot i occupies bits [i*ADDR_W +: ADDR_W]
- req_history_addr  in  SLOT_NUM*ADDR_W  per-slot history address; same packing
- req_ready  out  SLOT_NUM  per-slot accept; one-hot or zero
- pu_valid  out  1  to match_pu input_valid
- pu_slot_idx  out  SLOT_IDX_W  to match_pu input_slot_idx
- pu_is_burst  out  1  to match_pu input_is_burst
- pu_head_addr  out  ADDR_W  to match_pu input_head_addr
- pu_history_addr  out  ADDR_W  to match_pu input_history_addr
- pu_ready  in  1  from match_pu input_ready
- res_valid  in  1  from match_pu output_valid
- res_slot_idx  in  SLOT_IDX_W  from match_pu output_slot_idx
- res_match_len  in  MLEN_W  from match_pu output_match_len
- res_extp  in  1  from match_pu output_extp
- res_read_unsafe  in  1  from match_pu output_read_unsafe
- rsp_valid  out  SLOT_NUM  per-slot one-cycle response strobe
- rsp_match_len  out  MLEN_W  response data, shared by all slots
- rsp_extp  out  1  shared response flag
- rsp_read_unsafe  out  1  shared response flag
- outstanding  out  SLOT_NUM  bitmap of slots awaiting a response
- err_spurious  out  1  sticky: response arrived for a slot that was not outstanding
- err_timeout  out  1  sticky: watchdog fired; held 0 when the optional feature is off

Behaviour:
- Reset: all outputs 0; round-robin pointer = 0; issue register empty; outstanding = 0; both error flags = 0.
- Eligible slots: eligible[i] = req_valid[i] & ~outstanding[i].
- Grant: the first eligible slot at or after the pointer, searching upward with wrap-around.
- Issue register holds pu_valid and its payload.
- Load condition: load = |eligible & (~pu_valid | pu_ready).
- req_ready[grant] = load. It is combinational from req_valid, outstanding and pu_ready.
- On load:
  - Register the granted slot's fields.
  - Set outstanding[grant].
  - Pointer <= grant+1, modulo SLOT_NUM.
- pu_valid handshake:
  - pu_valid & pu_ready with no load: pu_valid <= 0 next cycle.
  - pu_valid & ~pu_ready: payload held stable.
- Latency: request accept to pu_valid is 1 cycle.
- Back-to-back: one request per cycle while pu_ready = 1.
- Burst: match_pu drops pu_ready for `MATCH_BURST_LEN-1 cycles after accepting a burst. No special burst state is needed here; the scheduler holds the issue register during that window.
- Response, registered (1-cycle latency):
  - On res_valid, rsp_valid[res_slot_idx] <= 1 with the data fields copied.
  - outstanding[res_slot_idx] is cleared in the same edge.
- Spurious response: res_valid for a slot with outstanding = 0.
  - rsp_valid is still generated.
  - err_spurious is set sticky until rst.
- Simultaneous set and clear:
  - Different slots in one cycle: both take effect.
  - Same slot in one cycle cannot occur, because an outstanding slot is ineligible.
- Reset mid-operation: in-flight requests are dropped. match_pu must be reset in the same cycle.

Optional Feature:
- Macro: MATCH_PU_SCHED_TIMEOUT_EN.
- Defined:
  - Each slot has an 8-bit watchdog counter.
  - The counter clears when its outstanding bit is set and increments each cycle while the bit stays set.
  - On reaching TIMEOUT: clear that outstanding bit, set err_timeout sticky, and emit no rsp_valid.
  - A later late response for that slot is then flagged as spurious.
- Undefined: no counters exist and err_timeout is tied to 0.

Test Plan:
- Single request: slot 2 req with head 0x100, history 0x40, pu_ready=1 held.
  - Cycle 0: req_ready = 0100.
  - Cycle 1: pu_valid=1, slot_idx=2, addresses 0x100/0x40.
  - res_valid with slot 2, len 9 → rsp_valid = 0100 next cycle, rsp_match_len = 9, outstanding back to 0.
- Round-robin: all 4 slots valid, no responses, pu_ready=1 → grants issued in order 0,1,2,3 on consecutive cycles.
  - Then no further grants; outstanding = 1111.
- Backpressure: slot 0 issues a burst, then pu_ready=0 for 3 cycles while slot 1 is valid.
  - pu_valid and payload stay stable for slot 1 across those cycles.
  - req_ready stays 0 until pu_ready returns.
- Same-cycle events: response for slot 0 arrives in the same cycle slot 3 is granted.
  - Result: outstanding clears bit 0 and sets bit 3.
  - Slot 0 is eligible again on the following cycle.
- Spurious response: res_valid with slot 1 while outstanding = 0000 → rsp_valid = 0010 and err_spurious = 1, held until rst.
- Timeout (MATCH_PU_SCHED_TIMEOUT_EN, TIMEOUT=16): slot 0 issued, no response.
  - At 16 cycles: outstanding[0] = 0, err_timeout = 1.
  - Slot 0 can be granted again afterwards.

Source files
------------

// File: rtl/match_pu_scheduler.sv
// match_pu_scheduler: shares one match_pu between SLOT_NUM request slots.
//   Round-robin picks one eligible slot per cycle and registers it into the
//   match_pu input stage. The block tracks one outstanding request per slot
//   and routes match_pu responses back to their slot as one-cycle strobes.
//
// Optional feature: define MATCH_PU_SCHED_TIMEOUT_EN to add an 8-bit watchdog
//   per slot. A request with no response after TIMEOUT cycles is dropped and
//   err_timeout is set. Without the macro there are no counters and
//   err_timeout is tied to 0.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req_valid/is_burst    per-slot request valid and burst flag
//   req_head_addr         per-slot head address, slot i at [i*ADDR_W +: ADDR_W]
//   req_history_addr      per-slot history address, same packing
//   req_ready             per-slot accept (combinational, one-hot or zero)
//   pu_*                  registered issue stage to the match_pu input
//   pu_ready              match_pu input ready
//   res_*                 match_pu output: valid, slot index, data fields
//   rsp_valid             per-slot one-cycle response strobe (registered)
//   rsp_match_len/extp/read_unsafe  shared registered response data
//   outstanding           bitmap of slots awaiting a response
//   err_spurious          sticky: response for a slot that was not outstanding
//   err_timeout           sticky: watchdog fired (0 when the feature is off)
module match_pu_scheduler #(
    parameter int unsigned SLOT_NUM   = 4,
    parameter int unsigned SLOT_IDX_W = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MLEN_W     = 6,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SLOT_NUM-1:0]      req_valid,
    input  logic [SLOT_NUM-1:0]      req_is_burst,
    input  logic [SLOT_NUM*ADDR_W-1:0] req_head_addr,
    input  logic [SLOT_NUM*ADDR_W-1:0] req_history_addr,
    output logic [SLOT_NUM-1:0]      req_ready,
    output logic                     pu_valid,
    output logic [SLOT_IDX_W-1:0]    pu_slot_idx,
    output logic                     pu_is_burst,
    output logic [ADDR_W-1:0]        pu_head_addr,
    output logic [ADDR_W-1:0]        pu_history_addr,
    input  logic                     pu_ready,
    input  logic                     res_valid,
    input  logic [SLOT_IDX_W-1:0]    res_slot_idx,
    input  logic [MLEN_W-1:0]        res_match_len,
    input  logic                     res_extp,
    input  logic                     res_read_unsafe,
    output logic [SLOT_NUM-1:0]      rsp_valid,
    output logic [MLEN_W-1:0]        rsp_match_len,
    output logic                     rsp_extp,
    output logic                     rsp_read_unsafe,
    output logic [SLOT_NUM-1:0]      outstanding,
    output logic                     err_spurious,
    output logic                     err_timeout
);

    logic                  r_pu_valid;
    logic [SLOT_IDX_W-1:0] r_pu_slot_idx;
    logic                  r_pu_is_burst;
    logic [ADDR_W-1:0]     r_pu_head_addr;
    logic [ADDR_W-1:0]     r_pu_history_addr;
    logic [SLOT_IDX_W-1:0] r_ptr;
    logic [SLOT_NUM-1:0]   r_outstanding;
    logic [SLOT_NUM-1:0]   r_rsp_valid;
    logic [MLEN_W-1:0]     r_rsp_match_len;
    logic                  r_rsp_extp;
    logic                  r_rsp_read_unsafe;
    logic                  r_err_spurious;

    logic [SLOT_NUM-1:0]   w_eligible;
    logic [SLOT_IDX_W-1:0] w_grant;
    logic                  w_found;
    logic                  w_load;
    logic [SLOT_NUM-1:0]   w_grant_oh;
    logic [SLOT_NUM-1:0]   w_res_oh;
    logic [SLOT_NUM-1:0]   w_timeout;
    logic [SLOT_IDX_W-1:0] w_ptr_nxt;

    assign w_eligible = req_valid & ~r_outstanding;

    // Round-robin search: first eligible slot at or after the pointer, wrapping.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < int'(SLOT_NUM); k++) begin
            automatic int idx = (int'(r_ptr) + k) % int'(SLOT_NUM);
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_grant = SLOT_IDX_W'(idx);
            end
        end
    end

    // A new request may enter when the issue register is empty or draining.
    assign w_load    = w_found & (~r_pu_valid | pu_ready);
    assign w_ptr_nxt = SLOT_IDX_W'((int'(w_grant) + 1) % int'(SLOT_NUM));

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[w_grant] = w_load;
    end

    always_comb begin
        w_res_oh               = '0;
        w_res_oh[res_slot_idx] = res_valid;
    end

    assign req_ready = w_grant_oh;

    // Issue register, outstanding tracking and response routing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pu_valid        <= 1'b0;
            r_pu_slot_idx     <= '0;
            r_pu_is_burst     <= 1'b0;
            r_pu_head_addr    <= '0;
            r_pu_history_addr <= '0;
            r_ptr             <= '0;
            r_outstanding     <= '0;
            r_rsp_valid       <= '0;
            r_rsp_match_len   <= '0;
            r_rsp_extp        <= 1'b0;
            r_rsp_read_unsafe <= 1'b0;
            r_err_spurious    <= 1'b0;
        end else begin
            if (w_load) begin
                r_pu_valid        <= 1'b1;
                r_pu_slot_idx     <= w_grant;
                r_pu_is_burst     <= req_is_burst[w_grant];
                r_pu_head_addr    <= req_head_addr[32'(w_grant)*ADDR_W +: ADDR_W];
                r_pu_history_addr <= req_history_addr[32'(w_grant)*ADDR_W +: ADDR_W];
                r_ptr             <= w_ptr_nxt;
            end else if (pu_ready) begin
                r_pu_valid <= 1'b0;
            end
            // Grant sets are applied last; a granted slot was not outstanding.
            r_outstanding <= (r_outstanding & ~w_res_oh & ~w_timeout) | w_grant_oh;
            r_rsp_valid   <= w_res_oh;
            if (res_valid) begin
                r_rsp_match_len   <= res_match_len;
                r_rsp_extp        <= res_extp;
                r_rsp_read_unsafe <= res_read_unsafe;
                if (!r_outstanding[res_slot_idx]) begin
                    r_err_spurious <= 1'b1;
                end
            end
        end
    end

`ifdef MATCH_PU_SCHED_TIMEOUT_EN
    logic [7:0] r_wdog [SLOT_NUM];
    logic       r_err_timeout;

    // Fire on the edge where the counter would reach TIMEOUT; a response in
    // the same cycle takes precedence.
    always_comb begin
        w_timeout = '0;
        for (int i = 0; i < int'(SLOT_NUM); i++) begin
            w_timeout[i] = r_outstanding[i] & ~w_res_oh[i] &
                           (r_wdog[i] == 8'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SLOT_NUM); i++) begin
                r_wdog[i] <= 8'd0;
            end
            r_err_timeout <= 1'b0;
        end else begin
            for (int i = 0; i < int'(SLOT_NUM); i++) begin
                if (w_grant_oh[i] || !r_outstanding[i]) begin
                    r_wdog[i] <= 8'd0;
                end else begin
                    r_wdog[i] <= r_wdog[i] + 8'd1;
                end
            end
            if (|w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = '0;
    assign err_timeout = 1'b0;
`endif

    assign pu_valid        = r_pu_valid;
    assign pu_slot_idx     = r_pu_slot_idx;
    assign pu_is_burst     = r_pu_is_burst;
    assign pu_head_addr    = r_pu_head_addr;
    assign pu_history_addr = r_pu_history_addr;
    assign outstanding     = r_outstanding;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_match_len   = r_rsp_match_len;
    assign rsp_extp        = r_rsp_extp;
    assign rsp_read_unsafe = r_rsp_read_unsafe;
    assign err_spurious    = r_err_spurious;

endmodule

// File: tb/tb_match_pu_scheduler.sv
// Directed bench for match_pu_scheduler: reset, single request, round-robin,
// backpressure, same-cycle set/clear, spurious response, watchdog.
module tb_match_pu_scheduler;
    localparam int unsigned SN = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned MW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [SN-1:0] req_valid;
    logic [SN-1:0] req_is_burst;
    logic [SN*AW-1:0] req_head_addr;
    logic [SN*AW-1:0] req_history_addr;
    logic [SN-1:0] req_ready;
    logic          pu_valid;
    logic [IW-1:0] pu_slot_idx;
    logic          pu_is_burst;
    logic [AW-1:0] pu_head_addr;
    logic [AW-1:0] pu_history_addr;
    logic          pu_ready;
    logic          res_valid;
    logic [IW-1:0] res_slot_idx;
    logic [MW-1:0] res_match_len;
    logic          res_extp;
    logic          res_read_unsafe;
    logic [SN-1:0] rsp_valid;
    logic [MW-1:0] rsp_match_len;
    logic          rsp_extp;
    logic          rsp_read_unsafe;
    logic [SN-1:0] outstanding;
    logic          err_spurious;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    match_pu_scheduler #(
        .SLOT_NUM(SN), .SLOT_IDX_W(IW), .ADDR_W(AW), .MLEN_W(MW), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_is_burst(req_is_burst),
        .req_head_addr(req_head_addr), .req_history_addr(req_history_addr),
        .req_ready(req_ready),
        .pu_valid(pu_valid), .pu_slot_idx(pu_slot_idx), .pu_is_burst(pu_is_burst),
        .pu_head_addr(pu_head_addr), .pu_history_addr(pu_history_addr),
        .pu_ready(pu_ready),
        .res_valid(res_valid), .res_slot_idx(res_slot_idx),
        .res_match_len(res_match_len), .res_extp(res_extp),
        .res_read_unsafe(res_read_unsafe),
        .rsp_valid(rsp_valid), .rsp_match_len(rsp_match_len),
        .rsp_extp(rsp_extp), .rsp_read_unsafe(rsp_read_unsafe),
        .outstanding(outstanding), .err_spurious(err_spurious),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid       = '0;
        req_is_burst    = '0;
        pu_ready        = 1'b1;
        res_valid       = 1'b0;
        res_slot_idx    = '0;
        res_match_len   = '0;
        res_extp        = 1'b0;
        res_read_unsafe = 1'b0;
        for (int i = 0; i < int'(SN); i++) begin
            req_head_addr[i*AW +: AW]    = 32'h1000 + 32'(i);
            req_history_addr[i*AW +: AW] = 32'h2000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pu_valid !== 1'b0) begin errors++; $display("FAIL reset_pu_valid got %b exp 0", pu_valid); end
        checks++; if (outstanding !== 4'b0000) begin errors++; $display("FAIL reset_outstanding got %b exp 0000", outstanding); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if ({err_spurious, err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {err_spurious, err_timeout}); end
        checks++; if (pu_head_addr !== 32'h0) begin errors++; $display("FAIL reset_pu_head got %h exp 0", pu_head_addr); end
    endtask

    task automatic test_single();
        do_reset();
        req_head_addr[2*AW +: AW]    = 32'h100;
        req_history_addr[2*AW +: AW] = 32'h40;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready got %b exp 0100", req_ready); end
        step();
        req_valid = '0;
        checks++; if (pu_valid !== 1'b1 || pu_slot_idx !== 2'd2) begin errors++; $display("FAIL single_issue got v=%b idx=%0d exp v=1 idx=2", pu_valid, pu_slot_idx); end
        checks++; if (pu_head_addr !== 32'h100 || pu_history_addr !== 32'h40) begin errors++; $display("FAIL single_addr got %h/%h exp 100/40", pu_head_addr, pu_history_addr); end
        checks++; if (outstanding !== 4'b0100) begin errors++; $display("FAIL single_out_set got %b exp 0100", outstanding); end
        step();
        checks++; if (pu_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", pu_valid); end
        res_valid = 1'b1; res_slot_idx = 2'd2; res_match_len = 6'd9;
        step();
        res_valid = 1'b0;
        checks++; if (rsp_valid !== 4'b0100 || rsp_match_len !== 6'd9) begin errors++; $display("FAIL single_rsp got %b len %0d exp 0100 len 9", rsp_valid, rsp_match_len); end
        checks++; if (outstanding !== 4'b0000 || err_spurious !== 1'b0) begin errors++; $display("FAIL single_out_clr got %b sp=%b exp 0000 sp=0", outstanding, err_spurious); end
        step();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_strobe got %b exp 0000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [SN-1:0] exp_oh;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_oh = 4'b0001 << k;
            #1;
            checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_ready%0d got %b exp %b", k, req_ready, exp_oh); end
            step();
            checks++; if (pu_slot_idx !== 2'(k) || pu_head_addr !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL rr_issue%0d got idx %0d head %h", k, pu_slot_idx, pu_head_addr); end
        end
        #1;
        checks++; if (req_ready !== 4'b0000 || outstanding !== 4'b1111) begin errors++; $display("FAIL rr_done got ready %b out %b exp 0000/1111", req_ready, outstanding); end
        step();
        checks++; if (pu_valid !== 1'b0) begin errors++; $display("FAIL rr_idle got %b exp 0", pu_valid); end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0001; req_is_burst = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_burst_ready got %b exp 0001", req_ready); end
        step();
        checks++; if (pu_is_burst !== 1'b1 || pu_slot_idx !== 2'd0) begin errors++; $display("FAIL bp_burst_issue got b=%b idx=%0d", pu_is_burst, pu_slot_idx); end
        req_valid = 4'b0011; req_is_burst = '0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_slot1_ready got %b exp 0010", req_ready); end
        step();
        pu_ready = 1'b0; req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready%0d got %b exp 0000", c, req_ready); end
            checks++; if (pu_valid !== 1'b1 || pu_slot_idx !== 2'd1 || pu_head_addr !== 32'h1001 || pu_history_addr !== 32'h2001) begin errors++; $display("FAIL bp_hold%0d got v=%b idx=%0d %h/%h", c, pu_valid, pu_slot_idx, pu_head_addr, pu_history_addr); end
            step();
        end
        pu_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume_ready got %b exp 0100", req_ready); end
        step();
        req_valid = '0;
        checks++; if (pu_slot_idx !== 2'd2 || pu_is_burst !== 1'b0) begin errors++; $display("FAIL bp_resume_issue got idx=%0d b=%b exp 2/0", pu_slot_idx, pu_is_burst); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1000;
        res_valid = 1'b1; res_slot_idx = 2'd0; res_match_len = 6'd3;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL same_ready got %b exp 1000", req_ready); end
        step();
        res_valid = 1'b0;
        checks++; if (outstanding !== 4'b1000 || rsp_valid !== 4'b0001) begin errors++; $display("FAIL same_out got %b rsp %b exp 1000/0001", outstanding, rsp_valid); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL same_regrant got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
        checks++; if (outstanding !== 4'b1001 || pu_slot_idx !== 2'd0) begin errors++; $display("FAIL same_reissue got %b idx %0d exp 1001/0", outstanding, pu_slot_idx); end
    endtask

    task automatic test_spurious();
        do_reset();
        res_valid = 1'b1; res_slot_idx = 2'd1; res_match_len = 6'd5;
        res_extp = 1'b1; res_read_unsafe = 1'b1;
        step();
        res_valid = 1'b0;
        checks++; if (rsp_valid !== 4'b0010 || err_spurious !== 1'b1) begin errors++; $display("FAIL spur_flag got rsp %b err %b exp 0010/1", rsp_valid, err_spurious); end
        checks++; if (rsp_extp !== 1'b1 || rsp_read_unsafe !== 1'b1 || rsp_match_len !== 6'd5) begin errors++; $display("FAIL spur_data got %b%b len %0d", rsp_extp, rsp_read_unsafe, rsp_match_len); end
        for (int c = 0; c < 5; c++) step();
        checks++; if (err_spurious !== 1'b1 || outstanding !== 4'b0000) begin errors++; $display("FAIL spur_sticky got %b out %b exp 1/0000", err_spurious, outstanding); end
        do_reset();
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spur_clear got %b exp 0", err_spurious); end
    endtask

    task automatic test_watchdog();
        do_reset();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        for (int c = 0; c < 15; c++) step();
        checks++; if (outstanding[0] !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL wd_before got out %b to %b exp 1/0", outstanding[0], err_timeout); end
        step();
`ifdef MATCH_PU_SCHED_TIMEOUT_EN
        checks++; if (outstanding[0] !== 1'b0 || err_timeout !== 1'b1 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL wd_fire got out %b to %b rsp %b", outstanding[0], err_timeout, rsp_valid); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wd_regrant got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
        step();
        res_valid = 1'b1; res_slot_idx = 2'd1;
        step();
        res_valid = 1'b0;
        checks++; if (err_spurious !== 1'b1 || err_timeout !== 1'b1) begin errors++; $display("FAIL wd_late got sp %b to %b exp 1/1", err_spurious, err_timeout); end
`else
        for (int c = 0; c < 10; c++) step();
        checks++; if (outstanding[0] !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL wd_off got out %b to %b exp 1/0", outstanding[0], err_timeout); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_same_cycle();
        test_spurious();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
